hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Next-generation hazard unit for the 5-stage MIPS datapath with branches resolved in ID.
//  Detects load-use and branch-operand hazards and drives PC/IF-ID write enables, the ID/EX bubble and IF.Flush.
//  Holds multi-cycle stalls via a counter FSM for multi-cycle memory (LOAD_LAT>1).
//  Keeps saturating stall/flush performance counters.
// PARAMETERS
//  REG_AW    5   register-index width
//  LOAD_LAT  1   stall cycles for a load-use hazard with the load in EX (1..7)
//  CNT_W     16  performance-counter width
// PORTS
//  clk            in   1       clock, all state updates on rising edge
//  reset          in   1       synchronous, active-high
//  id_valid       in   1       ID holds a real instruction
//  id_rs          in   REG_AW  ID source register rs
//  id_rt          in   REG_AW  ID source register rt
//  id_use_rs      in   1       ID instruction reads rs
//  id_use_rt      in   1       ID instruction reads rt
//  id_branch      in   1       ID instruction is BEQ
//  id_rsrt_equal  in   1       ID comparator result (rs==rt after forwarding)
//  ex_reg_write   in   1       EX instruction writes a register
//  ex_mem_read    in   1       EX instruction is a load
//  ex_rd          in   REG_AW  EX destination register
//  mem_mem_read   in   1       MEM instruction is a load
//  mem_rd         in   REG_AW  MEM destination register
//  pc_write       out  1       PC load enable
//  ifid_write     out  1       IF/ID load enable
//  idex_bubble    out  1       zero ID/EX control fields
//  if_flush       out  1       squash IF/ID (taken branch)
//  stall_cnt      out  CNT_W   saturating stall-cycle count
//  flush_cnt      out  CNT_W   saturating flush count
// BEHAVIOUR
//  - Dependency: dep(X,r) = id_valid & r!=0 & ((id_use_rs & id_rs==r) | (id_use_rt & id_rt==r)); register 0 never hazards.
//  - Required stall length L (combinational; first matching rule wins):
//      ex_mem_read & dep(ex_rd)                  -> L = LOAD_LAT + id_branch
//      id_branch & ex_reg_write & dep(ex_rd)     -> L = 1
//      id_branch & mem_mem_read & dep(mem_rd)    -> L = LOAD_LAT
//      otherwise                                 -> L = 0
//  - FSM states IDLE, HOLD; 3-bit down-counter rem.
//      IDLE: L>0 -> stall this cycle; if L>1, go HOLD with rem=L-1; else stay IDLE.
//      HOLD: stall unconditionally, ignore L; rem-=1; rem==1 -> return to IDLE next cycle.
//  - Stall is combinational, same cycle as detection: stall = (IDLE & L>0) | HOLD.
//      stall=1 -> pc_write=0, ifid_write=0, idex_bubble=1.
//      stall=0 -> pc_write=1, ifid_write=1, idex_bubble=0.
//  - if_flush = id_branch & id_rsrt_equal & id_valid & ~stall; one cycle per taken branch; never with stall.
//  - Counters: stall_cnt +1 per stall cycle; flush_cnt +1 per if_flush cycle; both saturate at 2^CNT_W-1, never wrap.
//  - Reset (sync): state=IDLE, rem=0, counters=0.
//      Outputs while reset high: pc_write=1, ifid_write=1, idex_bubble=0, if_flush=0.
//      Reset during HOLD aborts the stall; the first post-reset cycle re-evaluates L from the inputs.
//  - id_valid=0 -> L=0 and if_flush=0; an in-progress HOLD still completes.
//  - Latency: zero-cycle combinational decode. Only state, rem and counters are registered.
// TESTING
//  1 lw $2 in EX (ex_mem_read=1, ex_rd=2), add uses rs=2, LOAD_LAT=1
//    -> one cycle pc_write=0/idex_bubble=1, then free; stall_cnt=1.
//  2 Same as 1 with LOAD_LAT=3
//    -> exactly 3 consecutive stall cycles (IDLE,HOLD,HOLD), then pc_write=1; stall_cnt=3.
//  3 beq rs=4 with ALU write to $4 in EX
//    -> 1 stall; with lw $4 in EX and LOAD_LAT=1 -> 2 stalls.
//  4 beq, id_rsrt_equal=1, no hazard
//    -> if_flush=1 for 1 cycle, flush_cnt=1.
//    Same while hazard present -> if_flush=0 until stall ends.
//  5 ex_rd=0, ex_mem_read=1, id_rs=0
//    -> no stall. Preload counter at 2^CNT_W-1 -> stays saturated.
//  6 reset asserted mid-HOLD (LOAD_LAT=3, 2nd stall cycle)
//    -> pc_write=1 during reset, counters=0, no residual stall after release.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard unit for a 5-stage MIPS pipeline with branches resolved in ID.
// Detects load-use and branch-operand hazards, holds multi-cycle stalls, and counts stalls/flushes.
module hazard_stall_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_branch,
    input  logic              id_rsrt_equal,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              if_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state_q, state_d;
    logic [2:0] rem_q, rem_d;
    logic       dep_ex, dep_mem;
    logic [3:0] req_len;
    logic       fsm_stall, stall;

    // Register 0 is hard-wired, so it never creates a dependency.
    assign dep_ex  = id_valid && (ex_rd != '0) &&
                     ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    assign dep_mem = id_valid && (mem_rd != '0) &&
                     ((id_use_rs && (id_rs == mem_rd)) || (id_use_rt && (id_rt == mem_rd)));

    always_comb begin
        req_len = 4'd0;
        if (ex_mem_read && dep_ex)
            req_len = 4'(LOAD_LAT) + {3'b000, id_branch};
        else if (id_branch && ex_reg_write && dep_ex)
            req_len = 4'd1;
        else if (id_branch && mem_mem_read && dep_mem)
            req_len = 4'(LOAD_LAT);
    end

    // NOTE: every variable of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        fsm_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_len != 4'd0) begin
                    fsm_stall = 1'b1;
                    if (req_len > 4'd1) begin
                        state_d = HOLD;
                        rem_d   = 3'(req_len - 4'd1);
                    end
                end
            end
            HOLD: begin
                fsm_stall = 1'b1;
                rem_d     = rem_q - 3'd1;
                if (rem_q <= 3'd1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall       = fsm_stall && !reset;
    assign pc_write    = !stall;
    assign ifid_write  = !stall;
    assign idex_bubble = stall;
    assign if_flush    = id_branch && id_rsrt_equal && id_valid && !stall && !reset;

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rem_q     <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (if_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: two hazard units (LOAD_LAT=1 and 3) driven in parallel,
// compared every cycle against a countdown reference model.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs, id_use_rt, id_branch, id_rsrt_equal;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       ex_reg_write, ex_mem_read, mem_mem_read;

    logic       pc_w [2];
    logic       ifid_w [2];
    logic       bubble [2];
    logic       flush [2];
    logic [5:0] sc0, fc0;
    logic [7:0] sc1, fc1;

    int errors = 0;
    int checks = 0;

    const int lat_of [2] = '{1, 3};
    const int max_of [2] = '{63, 255};
    int left [2];
    int m_sc [2];
    int m_fc [2];

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(6)) u_lat1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_rsrt_equal(id_rsrt_equal), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
        .pc_write(pc_w[0]), .ifid_write(ifid_w[0]), .idex_bubble(bubble[0]),
        .if_flush(flush[0]), .stall_cnt(sc0), .flush_cnt(fc0));

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(8)) u_lat3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_rsrt_equal(id_rsrt_equal), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
        .pc_write(pc_w[1]), .ifid_write(ifid_w[1]), .idex_bubble(bubble[1]),
        .if_flush(flush[1]), .stall_cnt(sc1), .flush_cnt(fc1));

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit dep(input logic [4:0] r);
        return id_valid && (r != 0) &&
               ((id_use_rs && id_rs == r) || (id_use_rt && id_rt == r));
    endfunction

    // Required stall length straight from the hazard rules, first match wins.
    function automatic int need(input int lat);
        if (ex_mem_read && dep(ex_rd)) return lat + int'(id_branch);
        if (id_branch && ex_reg_write && dep(ex_rd)) return 1;
        if (id_branch && mem_mem_read && dep(mem_rd)) return lat;
        return 0;
    endfunction

    task automatic clear_inputs();
        reset = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_branch = 0; id_rsrt_equal = 0; ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0;
        mem_mem_read = 0; mem_rd = 0;
    endtask

    // Called just after a rising edge with inputs already applied.
    task automatic step();
        int  len [2];
        bit  st [2];
        bit  fl [2];
        #2;
        for (int i = 0; i < 2; i++) begin
            string p;
            p      = $sformatf("lat%0d", lat_of[i]);
            len[i] = need(lat_of[i]);
            st[i]  = !reset && (left[i] > 0 || len[i] > 0);
            fl[i]  = !reset && id_branch && id_rsrt_equal && id_valid && !st[i];
            check({p, "_pc_write"},    int'(pc_w[i]),   int'(!st[i]));
            check({p, "_ifid_write"},  int'(ifid_w[i]), int'(!st[i]));
            check({p, "_idex_bubble"}, int'(bubble[i]), int'(st[i]));
            check({p, "_if_flush"},    int'(flush[i]),  int'(fl[i]));
        end
        check("lat1_stall_cnt", int'(sc0), m_sc[0]);
        check("lat1_flush_cnt", int'(fc0), m_fc[0]);
        check("lat3_stall_cnt", int'(sc1), m_sc[1]);
        check("lat3_flush_cnt", int'(fc1), m_fc[1]);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                left[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
            end else begin
                if (left[i] > 0) left[i]--;
                else if (len[i] > 0) left[i] = len[i] - 1;
                if (st[i] && m_sc[i] < max_of[i]) m_sc[i]++;
                if (fl[i] && m_fc[i] < max_of[i]) m_fc[i]++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic lw_use(input logic [4:0] r);
        clear_inputs();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = r;
        id_valid = 1; id_rs = r; id_use_rs = 1;
    endtask

    initial begin
        int s0, s3, f0;
        clear_inputs();
        reset = 1;
        @(posedge clk); #1;
        do_reset();
        check("reset_stall_cnt", int'(sc1), 0);
        check("reset_flush_cnt", int'(fc0), 0);

        // load-use: lw $2 then add using $2, single cycle presentation
        lw_use(5'd2);
        step();
        clear_inputs();
        repeat (4) step();
        check("t1_stall_cnt_lat1", int'(sc0), 1);
        check("t2_stall_cnt_lat3", int'(sc1), 3);

        // branch with ALU producer in EX, then with load producer in EX
        s0 = int'(sc0); s3 = int'(sc1);
        clear_inputs();
        id_valid = 1; id_branch = 1; id_rs = 4; id_use_rs = 1; ex_reg_write = 1; ex_rd = 4;
        step();
        clear_inputs();
        repeat (3) step();
        check("t3_alu_lat1", int'(sc0) - s0, 1);
        check("t3_alu_lat3", int'(sc1) - s3, 1);
        s0 = int'(sc0); s3 = int'(sc1);
        lw_use(5'd4); id_branch = 1;
        step();
        clear_inputs();
        repeat (5) step();
        check("t3_lw_lat1", int'(sc0) - s0, 2);
        check("t3_lw_lat3", int'(sc1) - s3, 4);

        // taken branch with no hazard, then taken branch held while a hazard resolves
        f0 = int'(fc0);
        clear_inputs();
        id_valid = 1; id_branch = 1; id_rsrt_equal = 1; id_rs = 7; id_use_rs = 1;
        step();
        clear_inputs();
        step();
        check("t4_flush_once", int'(fc0) - f0, 1);
        id_valid = 1; id_branch = 1; id_rsrt_equal = 1; id_rs = 4; id_use_rs = 1;
        ex_mem_read = 1; ex_rd = 4;
        step();
        ex_mem_read = 0; ex_rd = 0;
        repeat (5) step();
        clear_inputs();
        step();

        // register 0 never hazards
        clear_inputs();
        ex_mem_read = 1; ex_rd = 0; id_valid = 1; id_rs = 0; id_use_rs = 1; id_branch = 1;
        mem_mem_read = 1; mem_rd = 0;
        #2;
        check("t5_r0_pc_write_lat1", int'(pc_w[0]), 1);
        check("t5_r0_pc_write_lat3", int'(pc_w[1]), 1);
        step();
        clear_inputs();

        // reset during HOLD (2nd stall cycle of the LOAD_LAT=3 unit)
        do_reset();
        lw_use(5'd3);
        step();
        clear_inputs();
        reset = 1;
        #2;
        check("t6_pc_write_in_reset", int'(pc_w[1]), 1);
        step();
        check("t6_stall_cnt_cleared", int'(sc1), 0);
        reset = 0;
        #2;
        check("t6_no_residual_stall", int'(pc_w[1]), 1);
        repeat (3) step();

        // saturation: a permanently present load-use hazard
        lw_use(5'd9);
        repeat (300) step();
        check("t5_sat_lat1", int'(sc0), 63);
        check("t5_sat_lat3", int'(sc1), 255);
        step();
        check("t5_sat_hold_lat3", int'(sc1), 255);

        // randomized traffic with occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 99) == 0);
            id_valid      = ($urandom_range(0, 7) != 0);
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            id_use_rs     = 1'($urandom);
            id_use_rt     = 1'($urandom);
            id_branch     = ($urandom_range(0, 2) == 0);
            id_rsrt_equal = 1'($urandom);
            ex_reg_write  = 1'($urandom);
            ex_mem_read   = ($urandom_range(0, 3) == 0);
            ex_rd         = 5'($urandom_range(0, 3));
            mem_mem_read  = ($urandom_range(0, 3) == 0);
            mem_rd        = 5'($urandom_range(0, 3));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
